// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The control word packs the five hold bits followed by the four bubble bits.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, HALT} state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] HALT_SVC = 32'd10;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic memwb_hold;
    logic ifid_bub;
    logic idex_bub;
    logic exmem_bub;
    logic memwb_bub;
  } ctrl_t;

  localparam ctrl_t CTRL_FREE  = 9'b00000_0000;
  localparam ctrl_t CTRL_STALL = 9'b11000_0100;
  localparam ctrl_t CTRL_FLUSH = 9'b00000_1100;
  // The memory-wait and halt words are identical: freeze IF..EX and bubble MEM/WB.
  localparam ctrl_t CTRL_MEMW  = 9'b11110_0001;
  localparam ctrl_t CTRL_HALT  = 9'b11110_0001;
  localparam ctrl_t CTRL_RST   = 9'b00000_1111;

  function automatic logic is_halt_svc(input logic [31:0] v0);
    return v0 == HALT_SVC;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The master side is the controller; PERF_CNT_EN adds the performance counters.
interface pipe_hazard_ctrl_if;

  logic [4:0] id_rs_no;
  logic [4:0] id_rt_no;
  logic       id_rs_used;
  logic       id_rt_used;
  logic       ex_MemRead;
  logic [4:0] ex_Rd_no;
  logic       ex_Effective;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       wb_Syscall;
  logic       wb_Effective;
  logic       wb_halt;
  logic       resume;

  logic       PC_Enable;
  logic       IFID_Enable;
  logic       IDEX_Enable;
  logic       EXMEM_Enable;
  logic       MEMWB_Enable;
  logic       IFID_rst;
  logic       IDEX_rst;
  logic       EXMEM_rst;
  logic       MEMWB_rst;
  logic       halted;
  logic       mem_err;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  logic [15:0] halt_count;
`endif

  modport master (
    input  id_rs_no, id_rt_no, id_rs_used, id_rt_used,
    input  ex_MemRead, ex_Rd_no, ex_Effective, ex_branch_taken,
    input  mem_req, mem_ready, wb_Syscall, wb_Effective, wb_halt, resume,
    output PC_Enable, IFID_Enable, IDEX_Enable, EXMEM_Enable, MEMWB_Enable,
    output IFID_rst, IDEX_rst, EXMEM_rst, MEMWB_rst, halted, mem_err
`ifdef PERF_CNT_EN
    , output stall_cycles, flush_events, halt_count
`endif
  );

  modport slave (
    output id_rs_no, id_rt_no, id_rs_used, id_rt_used,
    output ex_MemRead, ex_Rd_no, ex_Effective, ex_branch_taken,
    output mem_req, mem_ready, wb_Syscall, wb_Effective, wb_halt, resume,
    input  PC_Enable, IFID_Enable, IDEX_Enable, EXMEM_Enable, MEMWB_Enable,
    input  IFID_rst, IDEX_rst, EXMEM_rst, MEMWB_rst, halted, mem_err
`ifdef PERF_CNT_EN
    , input stall_cycles, flush_events, halt_count
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by ID.
// Register zero never creates a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_no,
  input  logic [4:0] id_rt_no,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_Rd_no,
  input  logic       ex_Effective,
  output logic       hz
);

  logic rs_dep;
  logic rt_dep;

  assign rs_dep = id_rs_used && (id_rs_no == ex_Rd_no);
  assign rt_dep = id_rt_used && (id_rt_no == ex_Rd_no);
  assign hz     = ex_Effective && ex_MemRead && (ex_Rd_no != REG_ZERO) && (rs_dep || rt_dep);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: drives hold/bubble controls for PC and the four pipeline registers.
// Define PERF_CNT_EN to add stall/flush/halt performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] TMO     = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] LU_LAST = CNT_W'(LU_STALL_CYCLES - 1);

  state_e           state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             mem_err_r, err_set;
  ctrl_t            ctl_run, ctl;
  logic             hz, mw, ht;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  load_use_detect u_lud (
    .id_rs_no     (bus.id_rs_no),
    .id_rt_no     (bus.id_rt_no),
    .id_rs_used   (bus.id_rs_used),
    .id_rt_used   (bus.id_rt_used),
    .ex_MemRead   (bus.ex_MemRead),
    .ex_Rd_no     (bus.ex_Rd_no),
    .ex_Effective (bus.ex_Effective),
    .hz           (hz)
  );

  assign mw = bus.mem_req && !bus.mem_ready;
  assign ht = bus.wb_Effective && bus.wb_Syscall && bus.wb_halt;

  always_comb begin
    ctl_run   = CTRL_FREE;
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    err_set   = 1'b0;
    case (state_r)
      RUN, LU_STALL, MEM_WAIT: begin
        if (ht) begin
          ctl_run   = CTRL_HALT;
          state_nxt = HALT;
          cnt_nxt   = '0;
        end else if (mw) begin
          ctl_run = CTRL_MEMW;
          if (state_r != MEM_WAIT) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = MEM_WAIT;
          end else begin
            cnt_nxt = sat_inc(cnt_r);
            if (cnt_nxt == TMO) begin
              err_set   = 1'b1;
              state_nxt = HALT;
            end
          end
        end else if (state_r == MEM_WAIT) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (state_r == LU_STALL) begin
          ctl_run = CTRL_STALL;
          if (cnt_r == LU_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = sat_inc(cnt_r);
          end
        end else if (bus.ex_branch_taken) begin
          // The ID instruction is squashed, so any load-use hit on it is moot.
          ctl_run = CTRL_FLUSH;
        end else if (hz) begin
          ctl_run = CTRL_STALL;
          if (LU_STALL_CYCLES > 1) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = LU_STALL;
          end
        end
      end
      default: begin
        ctl_run = CTRL_HALT;
        if (bus.resume) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  // While reset is held the whole pipeline is flushed, independent of the clock.
  assign ctl = rst ? ctl_run : CTRL_RST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= RUN;
      cnt_r     <= '0;
      mem_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      if (err_set) mem_err_r <= 1'b1;
    end
  end

  assign bus.PC_Enable    = ctl.pc_hold;
  assign bus.IFID_Enable  = ctl.ifid_hold;
  assign bus.IDEX_Enable  = ctl.idex_hold;
  assign bus.EXMEM_Enable = ctl.exmem_hold;
  assign bus.MEMWB_Enable = ctl.memwb_hold;
  assign bus.IFID_rst     = ctl.ifid_bub;
  assign bus.IDEX_rst     = ctl.idex_bub;
  assign bus.EXMEM_rst    = ctl.exmem_bub;
  assign bus.MEMWB_rst    = ctl.memwb_bub;
  assign bus.halted       = (state_r == HALT);
  assign bus.mem_err      = mem_err_r;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_events_r;
  logic [15:0] halt_count_r;
  logic        flush;

  assign flush = (state_r == RUN) && (ctl_run == CTRL_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= '0;
      flush_events_r <= '0;
      halt_count_r   <= '0;
    end else begin
      if (ctl_run.pc_hold && (state_r != HALT)) stall_cycles_r <= stall_cycles_r + 32'd1;
      if (flush) flush_events_r <= flush_events_r + 32'd1;
      if ((state_nxt == HALT) && (state_r != HALT)) halt_count_r <= halt_count_r + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_r;
  assign bus.flush_events = flush_events_r;
  assign bus.halt_count   = halt_count_r;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the four pipeline registers IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC register.
- Each cycle it drives every register's hold input (`*_Enable`, 1 = hold) and bubble input (`*_rst`, 1 = clear).
- It resolves load-use hazards, taken-branch/jump flushes, multi-cycle data-memory waits, and syscall halt/resume.
- Holds a small registered FSM. Stall/flush outputs are decoded combinationally from state and current inputs, so the registers see them at the same posedge.

Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3).
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before `mem_err` is raised.
- CNT_W, 8, width of the internal stall/timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset of the controller; distinct from the per-register bubble outputs.
- id_rs_no  in  5  rs register number of the instruction in ID.
- id_rt_no  in  5  rt register number of the instruction in ID.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- ex_MemRead  in  1  EX instruction is a load.
- ex_Rd_no  in  5  destination register of the EX instruction.
- ex_Effective  in  1  EX stage holds a valid instruction.
- ex_branch_taken  in  1  EX resolved a taken branch, jump, JR or JAL redirect.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- wb_Syscall  in  1  Syscall bit from the MEM/WB register.
- wb_Effective  in  1  MEM/WB holds a valid instruction.
- wb_halt  in  1  syscall service code means halt ($v0==10).
- resume  in  1  single-cycle pulse that restarts from HALT.
- PC_Enable  out  1  hold PC.
- IFID_Enable  out  1  hold IF/ID.
- IDEX_Enable  out  1  hold ID/EX.
- EXMEM_Enable  out  1  hold EX/MEM.
- MEMWB_Enable  out  1  hold MEM/WB.
- IFID_rst  out  1  bubble into IF/ID.
- IDEX_rst  out  1  bubble into ID/EX.
- EXMEM_rst  out  1  bubble into EX/MEM.
- MEMWB_rst  out  1  bubble into MEM/WB.
- halted  out  1  controller is in HALT.
- mem_err  out  1  sticky; set on memory-wait timeout.

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT, HALT.
- Reset (rst=0, async): state=RUN, counter=0, mem_err=0.
- While rst=0, every output is 0 except IFID_rst, IDEX_rst, EXMEM_rst and MEMWB_rst, which are 1 (pipeline flushed).
- Hazard terms:
  - hz = ex_Effective & ex_MemRead & ex_Rd_no!=0 & ((id_rs_used & id_rs_no==ex_Rd_no) | (id_rt_used & id_rt_no==ex_Rd_no)).
  - mw = mem_req & ~mem_ready.
  - ht = wb_Effective & wb_Syscall & wb_halt.
- Priority per cycle, highest first: ht > mw > ex_branch_taken > hz. The default is all outputs 0 (free flow).
- RUN:
  - ht: the syscall retires this cycle. Assert PC_, IFID_, IDEX_ and EXMEM_Enable, and MEMWB_rst. Next state HALT.
  - mw: all five Enable=1 except MEMWB_Enable=0, with MEMWB_rst=1 so no duplicate writeback. Counter=1. Next state MEM_WAIT.
  - ex_branch_taken: IFID_rst=1 and IDEX_rst=1, PC loads the target. Stay in RUN. A simultaneous hz is ignored because the ID instruction is being squashed.
  - hz: PC_Enable=1, IFID_Enable=1, IDEX_rst=1. If LU_STALL_CYCLES>1, counter=1 and next state LU_STALL; otherwise stay in RUN.
- LU_STALL:
  - Same outputs as hz.
  - Counter increments each cycle. When counter==LU_STALL_CYCLES-1, next state RUN and counter=0.
  - ht or mw arriving here preempts it using the RUN rules above.
- MEM_WAIT:
  - Outputs as for mw while mem_ready=0.
  - On mem_ready=1: outputs all 0 and next state RUN. The counter saturates at its maximum value (2^CNT_W−1).
  - If counter reaches MEM_TIMEOUT: set mem_err, then go to HALT.
- HALT:
  - PC_ through EXMEM_Enable are held at 1; MEMWB_rst=1; halted=1.
  - resume=1 → next state RUN, and halted drops the following cycle.
  - resume is ignored in every other state.
  - mem_err clears only on reset.
- An asynchronous reset asserted in any state aborts immediately; the pipeline registers see bubbles on the next posedge.
- Outputs are never X after reset; every output is assigned in every state.

Optional Feature:
- PERF_CNT_EN defined adds the following:
  - Outputs stall_cycles[31:0], flush_events[31:0] and halt_count[15:0], all reset to 0.
  - stall_cycles increments for every cycle in which PC_Enable=1 outside HALT.
  - flush_events increments for every branch flush.
  - halt_count increments on each HALT entry.
  - All three counters wrap modulo 2^width.
- PERF_CNT_EN undefined: these ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - State enum {RUN, LU_STALL, MEM_WAIT, HALT}.
  - REG_ZERO=5'd0.
  - HALT_SVC=32'd10.
- One sub-module, `load_use_detect`: purely combinational; computes hz from the ID/EX fields above.

Test Plan:
- `lw $8` in EX (ex_Rd_no=8, ex_MemRead=1) with `add` in ID reading rs=8 → exactly 1 cycle of PC_Enable=IFID_Enable=IDEX_rst=1, then free flow. With LU_STALL_CYCLES=2 → 2 cycles.
- Same hazard with ex_branch_taken=1 in the same cycle → IFID_rst=IDEX_rst=1, PC_Enable=0, no stall.
- mem_req=1 with mem_ready low for 4 cycles → 4 cycles of Enable=1 and MEMWB_rst=1; the cycle with mem_ready=1 shows all outputs 0 and state RUN.
- mem_ready held low 255 cycles with MEM_TIMEOUT=255 → mem_err=1, halted=1; mem_err remains 1 after resume.
- wb_Syscall=wb_Effective=wb_halt=1 → halted=1 from the next cycle and holds for 10 cycles; resume pulse → halted=0 one cycle later, flow restarts.
- rst dropped to 0 mid MEM_WAIT → all four *_rst=1 asynchronously, state RUN after release. With PERF_CNT_EN, counters read 0.
